// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: bundles the exception controller's pipeline/CP0 inputs and its
// CP0/fetch-side outputs.
//   master : pipeline side; drives the MEM-stage flags and forwarded CP0 values
//   slave  : exc_ctrl side; consumes them and drives excepttype/flush/redirect
interface exc_ctrl_if;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned FLAG_W = 4;

    logic              exc_valid_i;
    logic              mem_stall_i;
    logic [FLAG_W-1:0] exc_flags_i;     // {eret, trap, invalid_inst, syscall}
    logic [XLEN-1:0]   inst_addr_i;
    logic              in_delayslot_i;
    logic [XLEN-1:0]   cp0_status_i;
    logic [XLEN-1:0]   cp0_cause_i;
    logic [XLEN-1:0]   cp0_epc_i;

    logic [XLEN-1:0]   excepttype_o;
    logic [XLEN-1:0]   current_inst_address_o;
    logic              is_in_delayslot_o;
    logic              flush_o;
    logic [XLEN-1:0]   new_pc_o;
    logic              busy_o;

    modport master (
        output exc_valid_i, mem_stall_i, exc_flags_i, inst_addr_i, in_delayslot_i,
               cp0_status_i, cp0_cause_i, cp0_epc_i,
        input  excepttype_o, current_inst_address_o, is_in_delayslot_o,
               flush_o, new_pc_o, busy_o
    );

    modport slave (
        input  exc_valid_i, mem_stall_i, exc_flags_i, inst_addr_i, in_delayslot_i,
               cp0_status_i, cp0_cause_i, cp0_epc_i,
        output excepttype_o, current_inst_address_o, is_in_delayslot_o,
               flush_o, new_pc_o, busy_o
    );
endinterface

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/interrupt sequencer beside the MEM stage. Picks at most
// one event per commit (interrupt > syscall > invalid_inst > trap > eret),
// pulses its code to CP0 for one cycle, holds the pipeline flush for
// FLUSH_CYCLES cycles and supplies the redirect PC.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : exc_ctrl_if.slave (MEM-stage flags, forwarded CP0 values in;
//          excepttype, latched address/delay-slot, flush, new_pc, busy out)
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int unsigned FLUSH_CYCLES = 2            // legal 1..15
) (
    input  logic       clk,
    input  logic       rst,
    exc_ctrl_if.slave  bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    localparam logic [CNT_W-1:0] FCNT_LAST = CNT_W'(FLUSH_CYCLES - 1);

    localparam logic [XLEN-1:0] CODE_NONE = XLEN'(32'h00);
    localparam logic [XLEN-1:0] CODE_INT  = XLEN'(32'h01);
    localparam logic [XLEN-1:0] CODE_SYS  = XLEN'(32'h08);
    localparam logic [XLEN-1:0] CODE_INV  = XLEN'(32'h0a);
    localparam logic [XLEN-1:0] CODE_TRAP = XLEN'(32'h0d);
    localparam logic [XLEN-1:0] CODE_ERET = XLEN'(32'h0e);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic [XLEN-1:0]  exc_q, exc_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic             ds_q, ds_d;
    logic             flush_q, flush_d;
    logic [XLEN-1:0]  pc_q, pc_d;

    logic             int_pend_c;
    logic [XLEN-1:0]  code_c;
    logic             unused_c;

    // Interrupt pending: unmasked cause bit, IE set, EXL clear.
    assign int_pend_c = (|(bus.cp0_cause_i[15:8] & bus.cp0_status_i[15:8]))
                        && bus.cp0_status_i[0] && !bus.cp0_status_i[1];

    // Fixed-priority code; lower-priority flags in the same cycle are dropped.
    always_comb begin
        code_c = CODE_NONE;
        if (int_pend_c)               code_c = CODE_INT;
        else if (bus.exc_flags_i[0])  code_c = CODE_SYS;
        else if (bus.exc_flags_i[1])  code_c = CODE_INV;
        else if (bus.exc_flags_i[2])  code_c = CODE_TRAP;
        else if (bus.exc_flags_i[3])  code_c = CODE_ERET;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
            exc_q   <= '0;
            addr_q  <= '0;
            ds_q    <= 1'b0;
            flush_q <= 1'b0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            exc_q   <= exc_d;
            addr_q  <= addr_d;
            ds_q    <= ds_d;
            flush_q <= flush_d;
            pc_q    <= pc_d;
        end
    end

    // Next state and next registered outputs; excepttype defaults to zero so
    // it is a single-cycle pulse.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        exc_d   = CODE_NONE;
        addr_d  = addr_q;
        ds_d    = ds_q;
        flush_d = flush_q;
        pc_d    = pc_q;

        unique case (state_q)
            IDLE: begin
                if (bus.exc_valid_i && !bus.mem_stall_i && (code_c != CODE_NONE)) begin
                    exc_d   = code_c;
                    addr_d  = bus.inst_addr_i;
                    ds_d    = bus.in_delayslot_i;
                    pc_d    = (code_c == CODE_ERET) ? bus.cp0_epc_i : EXC_VECTOR;
                    flush_d = 1'b1;
                    fcnt_d  = '0;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Inputs are ignored here; the pipeline is being discarded.
                if (fcnt_q == FCNT_LAST) begin
                    flush_d = 1'b0;
                    fcnt_d  = '0;
                    state_d = IDLE;
                end else begin
                    fcnt_d  = fcnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.excepttype_o           = exc_q;
    assign bus.current_inst_address_o = addr_q;
    assign bus.is_in_delayslot_o      = ds_q;
    assign bus.flush_o                = flush_q;
    assign bus.new_pc_o               = pc_q;
    assign bus.busy_o                 = (state_q == FLUSH);

    // CP0 bits outside the IM/IP/IE/EXL fields are not used here.
    assign unused_c = ^{bus.cp0_cause_i[31:16], bus.cp0_cause_i[7:0],
                        bus.cp0_status_i[31:16], bus.cp0_status_i[7:2]};
endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception and interrupt controller sequencing the CP0 register block and the pipeline on every exception, interrupt or `eret`. It sits beside the MEM stage and monitors the committing instruction's exception flags and the forwarded CP0 Status/Cause/EPC values. It chooses at most one event per commit, presents it to CP0 as a one-cycle `excepttype`, flushes the pipeline for a programmable number of cycles, and supplies the redirect PC.

## Interface
Parameters:
- `EXC_VECTOR`, 32'h0000_0020, redirect target for all exceptions and interrupts.
- `FLUSH_CYCLES`, 2, number of cycles `flush_o` is held; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `exc_valid_i`  in  1  MEM-stage instruction valid and committing this cycle.
- `mem_stall_i`  in  1  MEM stage stalled; no event accepted while high.
- `exc_flags_i`  in  4  {eret, trap, invalid_inst, syscall} from the MEM-stage instruction.
- `inst_addr_i`  in  32  address of the MEM-stage instruction.
- `in_delayslot_i`  in  1  MEM-stage instruction sits in a delay slot.
- `cp0_status_i`, `cp0_cause_i`, `cp0_epc_i`  in  32 each  forwarded CP0 values, including any same-cycle CP0 write.
- `excepttype_o`  out  32  event code to CP0; nonzero for exactly one cycle per event.
- `current_inst_address_o`  out  32  latched `inst_addr_i` of the accepted event.
- `is_in_delayslot_o`  out  1  latched `in_delayslot_i` of the accepted event.
- `flush_o`  out  1  pipeline flush.
- `new_pc_o`  out  32  redirect PC; valid while `flush_o` is high.
- `busy_o`  out  1  controller not in IDLE.

## Operation
- States: IDLE and FLUSH. A 4-bit counter `fcnt` tracks FLUSH progress.
- Interrupt pending condition: `(cp0_cause_i[15:8] & cp0_status_i[15:8]) != 0`, with `status[0]` (IE) = 1 and `status[1]` (EXL) = 0.
- Event qualification in IDLE requires `exc_valid_i` = 1 and `mem_stall_i` = 0. If either fails, nothing is accepted and a pending interrupt keeps waiting.
- Fixed priority, highest first, with codes:
  - interrupt 32'h01
  - syscall 32'h08
  - invalid_inst 32'h0a
  - trap 32'h0d
  - eret 32'h0e
- Only the winning code is issued. All other flags in the same cycle are dropped.
- EXL = 1 blocks only the interrupt. Synchronous exceptions and `eret` are taken regardless.
- On acceptance, the following are registered:
  - `excepttype_o` = code.
  - `current_inst_address_o` and `is_in_delayslot_o` from the inputs.
  - `new_pc_o` = `cp0_epc_i` for `eret`, otherwise `EXC_VECTOR`.
  - `flush_o` = 1, `fcnt` = 0, state ← FLUSH.
- In FLUSH:
  - `excepttype_o` returns to 0 after the first cycle.
  - `flush_o`, `new_pc_o`, `current_inst_address_o` and `is_in_delayslot_o` hold.
  - `fcnt` increments each cycle.
  - When `fcnt` = `FLUSH_CYCLES`-1, the next edge clears `flush_o` and returns to IDLE.
- All inputs are ignored in FLUSH. No event is queued, and anything arriving in FLUSH is lost by design because the pipeline is being flushed.
- `busy_o` = (state == FLUSH).

## Timing
- Reset (`rst` = 0, immediate and asynchronous):
  - state IDLE, `fcnt` = 0.
  - `excepttype_o`, `current_inst_address_o`, `new_pc_o` = 32'h0.
  - `is_in_delayslot_o`, `flush_o`, `busy_o` = 0.
- Reset asserted mid-FLUSH aborts the flush at once. After release, the controller is in IDLE with no residual event.
- Latency: event qualified in cycle N → outputs set at edge N+1.
  - `excepttype_o` nonzero only in cycle N+1.
  - `flush_o` high in cycles N+1 through N+`FLUSH_CYCLES`.
  - IDLE again in cycle N+`FLUSH_CYCLES`+1. An event qualified in that cycle is accepted.
- `new_pc_o` is stable for the whole time `flush_o` is high and retains its last value afterwards.
- CP0 values are sampled only in the acceptance cycle. Later changes do not alter `new_pc_o`.

## Test plan
- Syscall: `exc_flags_i` = 4'b0001, `exc_valid_i` = 1, addr 32'h100 → next cycle `excepttype_o` = 32'h08, `current_inst_address_o` = 32'h100, `new_pc_o` = 32'h20; with the default `FLUSH_CYCLES`, `flush_o` is high for exactly 2 cycles, then IDLE.
- Interrupt masking:
  - cause[15:8] = 8'h04, status = 32'h0000_0401 → `excepttype_o` = 32'h01.
  - Same with status[1] = 1, or `mem_stall_i` = 1 → no event, `busy_o` stays 0.
- Priority: interrupt pending plus flags 4'b1111 → only 32'h01 is issued, one pulse, and `busy_o` high for `FLUSH_CYCLES` cycles.
- Eret: flags 4'b1000, `cp0_epc_i` = 32'h0000_1234 → `excepttype_o` = 32'h0e, `new_pc_o` = 32'h1234; changing `cp0_epc_i` during FLUSH leaves `new_pc_o` unchanged.
- Back-to-back: trap accepted, then invalid_inst held asserted → the invalid_inst `excepttype_o` = 32'h0a appears exactly `FLUSH_CYCLES`+1 cycles after the trap pulse; the `in_delayslot_i` = 1 case is latched into `is_in_delayslot_o`.
- Reset: `rst` dropped in the 1st FLUSH cycle with `FLUSH_CYCLES` = 4 → all outputs 0 immediately; after release, no pulse and `flush_o` = 0.
